// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the round-robin memory arbiter.
//   arb_state_e        : arbiter FSM states (IDLE, BUSY, RESP)
//   DEFAULT_LINE_WIDTH : default cache line width in bits
//   rv32i_word         : 32-bit word, the natural address type when ADDR_WIDTH = 32
package arbiter_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam int DEFAULT_LINE_WIDTH = 256;

   typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin selector.
// Scans the request vector starting at rr_ptr and moving upward, wrapping at
// NUM_PORTS, and reports the first requesting port.
//   req   : per-port request vector
//   ptr   : port with highest priority this round
//   valid : at least one port is requesting
//   idx   : index of the winning port (0 when valid is low)
module rr_pick #(
   parameter int NUM_PORTS = 2,
   parameter int IDX_WIDTH = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic                 valid,
   output logic [IDX_WIDTH-1:0] idx
);

   // Walk offsets from farthest to nearest so the last hit written is the
   // closest port at or above ptr.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_PORTS]) begin
            valid = 1'b1;
            idx   = IDX_WIDTH'((int'(ptr) + k) % NUM_PORTS);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter between NUM_PORTS cache-line
// requesters and a single physical-memory port.
//   clk, rst                 : clock, synchronous active-high reset
//   req_read / req_write     : per-port line read / write requests
//   req_addr / req_wdata     : per-port address and write line
//   req_resp                 : one-hot completion pulse to the granted port
//   req_rdata                : returned line, shared by all ports
//   pmem_read / pmem_write   : memory commands (from latched registers only)
//   pmem_address / pmem_wdata: latched address and write line
//   pmem_rdata / pmem_resp   : memory read line and completion
// Handshake: a requester holds its request, address and data stable until it
// sees its req_resp bit high, and drops the request on the edge that samples
// req_resp. The arbiter keeps one grant for a whole memory transaction;
// pmem holds the command until it raises pmem_resp for one cycle.
module mem_arbiter_rr
   import arbiter_types::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
   parameter int ADDR_WIDTH = 32,
   parameter int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_PORTS-1:0]                  req_read,
   input  logic [NUM_PORTS-1:0]                  req_write,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]                  req_resp,
   output logic [LINE_WIDTH-1:0]                 req_rdata,
   output logic                                  pmem_read,
   output logic                                  pmem_write,
   output logic [ADDR_WIDTH-1:0]                 pmem_address,
   output logic [LINE_WIDTH-1:0]                 pmem_wdata,
   input  logic [LINE_WIDTH-1:0]                 pmem_rdata,
   input  logic                                  pmem_resp
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PORTS - 1);

   arb_state_e             state_q,  state_d;
   logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_WIDTH-1:0]   grant_q,  grant_d;
   logic [ADDR_WIDTH-1:0]  addr_q,   addr_d;
   logic [LINE_WIDTH-1:0]  wdata_q,  wdata_d;
   logic                   write_q,  write_d;
   logic [LINE_WIDTH-1:0]  rdata_q,  rdata_d;

   logic [NUM_PORTS-1:0]   req_any;
   logic                   pick_valid;
   logic [IDX_WIDTH-1:0]   pick_idx;

   assign req_any = req_read | req_write;

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .req   (req_any),
      .ptr   (rr_ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               addr_d  = req_addr[pick_idx];
               wdata_d = req_wdata[pick_idx];
               // A port asserting both read and write is treated as a write.
               write_d = req_write[pick_idx];
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (pmem_resp) begin
               rdata_d  = pmem_rdata;
               rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_WIDTH'(1);
               state_d  = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         rdata_q  <= rdata_d;
      end
   end

   // Outputs decode only from state and latched registers.
   assign pmem_read    = (state_q == BUSY) && !write_q;
   assign pmem_write   = (state_q == BUSY) &&  write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign req_rdata    = rdata_q;

   always_comb begin
      req_resp = '0;
      if (state_q == RESP) req_resp[grant_q] = 1'b1;
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;
   import arbiter_types::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- 2-port DUT ----------------
   logic [1:0]         req_read, req_write, req_resp;
   logic [1:0][31:0]   req_addr;
   logic [1:0][255:0]  req_wdata;
   logic [255:0]       req_rdata, pmem_wdata, pmem_rdata;
   logic               pmem_read, pmem_write, pmem_resp;
   rv32i_word          pmem_address;

   mem_arbiter_rr dut (
      .clk(clk), .rst(rst),
      .req_read(req_read), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_resp(req_resp), .req_rdata(req_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   // ---------------- 3-port DUT (wrap-around) ----------------
   logic [2:0]         n3_read, n3_write, n3_resp;
   logic [2:0][31:0]   n3_addr;
   logic [2:0][31:0]   n3_wdata;
   logic [31:0]        n3_rdata, n3_pwdata, n3_prdata, n3_paddr;
   logic               n3_pread, n3_pwrite, n3_presp;

   mem_arbiter_rr #(.NUM_PORTS(3), .LINE_WIDTH(32), .ADDR_WIDTH(32)) dut3 (
      .clk(clk), .rst(rst),
      .req_read(n3_read), .req_write(n3_write),
      .req_addr(n3_addr), .req_wdata(n3_wdata),
      .req_resp(n3_resp), .req_rdata(n3_rdata),
      .pmem_read(n3_pread), .pmem_write(n3_pwrite),
      .pmem_address(n3_paddr), .pmem_wdata(n3_pwdata),
      .pmem_rdata(n3_prdata), .pmem_resp(n3_presp)
   );

   // ---------------- scoreboard ----------------
   logic [255:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [255:0] obs);
      logic [255:0] exp;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         check(tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Precondition: at a negedge of an IDLE cycle with requests already driven.
   // Ends at the negedge of the RESP cycle.
   task automatic run_txn(input int port, input bit is_write, input logic [31:0] addr,
                          input logic [255:0] wdata, input int wait_cycles,
                          input bit scramble);
      logic [255:0] rdata;
      logic [1:0]   oh;
      rdata = {8{$urandom()}};
      exp_q.push_back(rdata);
      for (int c = 0; c < wait_cycles; c++) begin
         @(negedge clk);
         check("pmem_read",  {255'd0, pmem_read},  {255'd0, !is_write});
         check("pmem_write", {255'd0, pmem_write}, {255'd0, is_write});
         check("pmem_address", {224'd0, pmem_address}, {224'd0, addr});
         if (is_write) check("pmem_wdata", pmem_wdata, wdata);
         if (scramble) begin
            req_addr[port]  = $urandom();
            req_wdata[port] = {8{$urandom()}};
         end
         if (c == wait_cycles - 1) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rdata;
         end
      end
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = {8{$urandom()}};
      oh = '0;
      oh[port] = 1'b1;
      check("req_resp", {254'd0, req_resp}, {254'd0, oh});
      check("resp_cmd_low", {254'd0, pmem_read, pmem_write}, 256'd0);
      check_pop("req_rdata", req_rdata);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;
      n3_read = '0; n3_write = '0; n3_addr = '0; n3_wdata = '0;
      n3_prdata = '0; n3_presp = 1'b0;

      // Reset state
      do_reset();
      check("rst_pmem_read",  {255'd0, pmem_read},  256'd0);
      check("rst_pmem_write", {255'd0, pmem_write}, 256'd0);
      check("rst_req_resp",   {254'd0, req_resp},   256'd0);
      check("rst_req_rdata",  req_rdata,            256'd0);
      check("rst_address",    {224'd0, pmem_address}, 256'd0);
      check("rst_rr_ptr",     {255'd0, dut.rr_ptr_q}, 256'd0);

      // Single read: port 1, 4-cycle memory latency, known line
      req_read    = 2'b10;
      req_addr[1] = 32'h0000_1000;
      begin
         logic [255:0] aa;
         aa = {32{8'hAA}};
         exp_q.push_back(aa);
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("single_read", {255'd0, pmem_read}, 256'd1);
            check("single_addr", {224'd0, pmem_address}, 256'h1000);
            if (c == 3) begin pmem_resp = 1'b1; pmem_rdata = aa; end
         end
         @(negedge clk);
         pmem_resp = 1'b0;
         check("single_resp", {254'd0, req_resp}, 256'd2);
         check_pop("single_rdata", req_rdata);
         req_read = '0;
         @(negedge clk);
         check("single_resp_gone", {254'd0, req_resp}, 256'd0);
         check("single_rdata_hold", req_rdata, aa);
         check("single_rr_ptr", {255'd0, dut.rr_ptr_q}, 256'd0);
      end

      // Contention fairness from reset: order 0,1,0,1
      do_reset();
      req_read    = 2'b11;
      req_addr[0] = 32'h0000_0100;
      req_addr[1] = 32'h0000_0200;
      for (int i = 0; i < 4; i++) begin
         run_txn(i % 2, 1'b0, (i % 2 == 0) ? 32'h100 : 32'h200, '0, 1 + i, 1'b0);
         @(negedge clk);
         check("fair_rr_ptr", {255'd0, dut.rr_ptr_q}, 256'((i + 1) % 2));
      end

      // Stability: port 0 write, inputs scrambled mid-BUSY
      req_read     = '0;
      req_write    = 2'b01;
      req_addr[0]  = 32'h0000_2000;
      req_wdata[0] = {64{4'h5}};
      run_txn(0, 1'b1, 32'h2000, {64{4'h5}}, 3, 1'b1);
      req_write = '0;
      @(negedge clk);
      check("stab_rr_ptr", {255'd0, dut.rr_ptr_q}, 256'd1);

      // Read+write on the same port: write wins
      req_read     = 2'b01;
      req_write    = 2'b01;
      req_addr[0]  = 32'h0000_3000;
      req_wdata[0] = {8{32'h1234_5678}};
      run_txn(0, 1'b1, 32'h3000, {8{32'h1234_5678}}, 2, 1'b0);
      req_read = '0; req_write = '0;
      @(negedge clk);

      // Reset mid-BUSY, then a late pmem_resp
      req_read    = 2'b01;
      req_addr[0] = 32'h0000_4000;
      @(negedge clk);
      check("midbusy_read", {255'd0, pmem_read}, 256'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req_read = '0;
      check("midrst_pmem_read", {255'd0, pmem_read}, 256'd0);
      check("midrst_req_resp",  {254'd0, req_resp},  256'd0);
      check("midrst_rr_ptr",    {255'd0, dut.rr_ptr_q}, 256'd0);
      check("midrst_address",   {224'd0, pmem_address}, 256'd0);
      check("midrst_rdata",     req_rdata, 256'd0);
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("late_resp_ignored", {254'd0, req_resp}, 256'd0);
         check("late_resp_cmd", {254'd0, pmem_read, pmem_write}, 256'd0);
      end

      // Wrap-around on the 3-port instance
      n3_read    = 3'b100;
      n3_addr[2] = 32'h0000_0C00;
      n3_addr[0] = 32'h0000_0A00;
      n3_addr[1] = 32'h0000_0B00;
      @(negedge clk);
      check("w3_read_p2", {224'd0, n3_paddr}, 256'h0C00);
      n3_presp  = 1'b1;
      n3_prdata = 32'hDEAD_BEEF;
      exp_q.push_back(256'hDEAD_BEEF);
      @(negedge clk);
      n3_presp = 1'b0;
      check("w3_resp_p2", {253'd0, n3_resp}, 256'd4);
      check_pop("w3_rdata", {224'd0, n3_rdata});
      n3_read = 3'b011;
      @(negedge clk);
      check("w3_rr_ptr", {254'd0, dut3.rr_ptr_q}, 256'd0);
      @(negedge clk);
      check("w3_wrap_addr", {224'd0, n3_paddr}, 256'h0A00);
      n3_presp  = 1'b1;
      n3_prdata = 32'h0BAD_F00D;
      exp_q.push_back(256'h0BAD_F00D);
      @(negedge clk);
      n3_presp = 1'b0;
      check("w3_wrap_resp", {253'd0, n3_resp}, 256'd1);
      check_pop("w3_wrap_rdata", {224'd0, n3_rdata});
      n3_read = 3'b010;
      @(negedge clk);
      check("w3_rr_ptr_after", {254'd0, dut3.rr_ptr_q}, 256'd1);
      n3_read = '0;

      // Final report
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
